// File: rtl/ma_pkg.sv
// ma_pkg: shared encodings and helpers for the MIPS64 memory-access stage.
//   - rw_e operation encodings (MA_NONE / MA_ST / MA_LDS / MA_LDU)
//   - rw_len access-size encodings (LEN_B / LEN_H / LEN_W / LEN_D)
//   - MA stage state enum (IDLE / REQ / WAIT / OUT)
//   - small helpers used when decoding an incoming transaction
package ma_pkg;

  typedef enum logic [1:0] {
    MA_NONE = 2'b00,
    MA_ST   = 2'b01,
    MA_LDS  = 2'b10,
    MA_LDU  = 2'b11
  } ma_rw_e;

  typedef enum logic [1:0] {
    LEN_B = 2'b00,
    LEN_H = 2'b01,
    LEN_W = 2'b10,
    LEN_D = 2'b11
  } ma_len_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    OUT  = 2'b11
  } ma_state_e;

  // Both load encodings have the upper bit set.
  function automatic logic is_load(input ma_rw_e op);
    return op[1];
  endfunction

  // A 32-bit bus cannot carry a double; such accesses degrade to a word.
  function automatic ma_len_e clamp_len(input ma_len_e len, input int data_l);
    if (data_l == 32 && len == LEN_D) return LEN_W;
    return len;
  endfunction

endpackage

// File: rtl/ma_load_align.sv
// ma_load_align: combinational lane steering for the memory-access stage.
// Parameter: DATA_L - bus width in bits (32 or 64).
// Ports:
//   off       in  byte offset of the access within the bus word
//   len       in  access size (byte/half/word/double)
//   is_signed in  sign-extend the extracted load value
//   st_data   in  right-aligned store data
//   rd_data   in  full-bus load data from memory
//   be        out byte enables for the access
//   wdata     out store data shifted into its byte lanes
//   ld_data   out extracted, extended load result
module ma_load_align
  import ma_pkg::*;
#(
  parameter int DATA_L = 64
) (
  input  logic [$clog2(DATA_L/8)-1:0] off,
  input  ma_len_e                     len,
  input  logic                        is_signed,
  input  logic [DATA_L-1:0]           st_data,
  input  logic [DATA_L-1:0]           rd_data,
  output logic [DATA_L/8-1:0]         be,
  output logic [DATA_L-1:0]           wdata,
  output logic [DATA_L-1:0]           ld_data
);

  localparam int BE_L = DATA_L / 8;

  logic [DATA_L-1:0] shifted;
  logic [DATA_L-1:0] mask;
  logic [BE_L-1:0]   be_base;
  logic              sign_bit;

  // mask keeps the bytes of the access; everything above it is filled with
  // either zeros or copies of the access's top bit.
  always_comb begin
    shifted  = rd_data >> {off, 3'b000};
    mask     = '1;
    be_base  = '1;
    sign_bit = shifted[DATA_L-1];
    case (len)
      LEN_B: begin
        mask     = DATA_L'(8'hFF);
        be_base  = BE_L'(1'b1);
        sign_bit = shifted[7];
      end
      LEN_H: begin
        mask     = DATA_L'(16'hFFFF);
        be_base  = BE_L'(2'b11);
        sign_bit = shifted[15];
      end
      LEN_W: begin
        mask     = DATA_L'(32'hFFFF_FFFF);
        be_base  = BE_L'(4'hF);
        sign_bit = shifted[31];
      end
      LEN_D: begin
        mask     = '1;
        be_base  = '1;
        sign_bit = shifted[DATA_L-1];
      end
    endcase
    ld_data = (shifted & mask) | ((is_signed && sign_bit) ? ~mask : '0);
    be      = be_base << off;
    wdata   = st_data << {off, 3'b000};
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MIPS64 memory-access pipeline stage between EX and WB.
// Valid/ready handshake upstream (EX) and downstream (WB), variable-latency
// request/grant/response memory port, byte..double accesses with byte
// enables and signed/unsigned load extension.
// Parameters: DATA_L (bus width, 32/64), MADDR_L (byte address width),
//             RIDX_L (register index width).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   up_valid/up_ready              EX handshake
//   rw_e, rw_len, rd, ex_ans,
//   ex_din, ex_wb_e                transaction fields from EX
//   mem_req/we/addr/be/wdata       memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata memory grant and load response
//   down_valid/down_ready          WB handshake
//   wb_e, wb_idx, wb_out           writeback result
//   misalign                       misaligned-access flag
// Build option: define MA_MISALIGN_EN to trap misaligned memory ops instead
// of forcing natural alignment; otherwise misalign is tied low.
module pipe_mem_stage
  import ma_pkg::*;
#(
  parameter int DATA_L  = 64,
  parameter int MADDR_L = 32,
  parameter int RIDX_L  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up_valid,
  output logic                up_ready,
  input  logic [1:0]          rw_e,
  input  logic [1:0]          rw_len,
  input  logic [RIDX_L-1:0]   rd,
  input  logic [MADDR_L-1:0]  ex_ans,
  input  logic [DATA_L-1:0]   ex_din,
  input  logic                ex_wb_e,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MADDR_L-1:0]  mem_addr,
  output logic [DATA_L/8-1:0] mem_be,
  output logic [DATA_L-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_L-1:0]   mem_rdata,
  output logic                down_valid,
  input  logic                down_ready,
  output logic                wb_e,
  output logic [RIDX_L-1:0]   wb_idx,
  output logic [DATA_L-1:0]   wb_out,
  output logic                misalign
);

  localparam int BE_L  = DATA_L / 8;
  localparam int OFF_L = $clog2(BE_L);

  ma_state_e          state_q, state_d;
  logic               mem_we_q, mem_we_d;
  logic [MADDR_L-1:0] mem_addr_q, mem_addr_d;
  logic [BE_L-1:0]    mem_be_q, mem_be_d;
  logic [DATA_L-1:0]  mem_wdata_q, mem_wdata_d;
  logic               wb_e_q, wb_e_d;
  logic [RIDX_L-1:0]  wb_idx_q, wb_idx_d;
  logic [DATA_L-1:0]  wb_out_q, wb_out_d;
  logic [OFF_L-1:0]   off_q, off_d;
  ma_len_e            len_q, len_d;
  logic               sign_q, sign_d;
  logic               load_q, load_d;
  logic               ex_wb_e_q, ex_wb_e_d;

  ma_rw_e             op_in;
  ma_len_e            len_in;
  logic [OFF_L-1:0]   off_in;
  logic [OFF_L-1:0]   align_mask;
  logic [OFF_L-1:0]   off_fix;

  logic [OFF_L-1:0]   la_off;
  ma_len_e            la_len;
  logic [BE_L-1:0]    la_be;
  logic [DATA_L-1:0]  la_wdata;
  logic [DATA_L-1:0]  la_ld;

`ifdef MA_MISALIGN_EN
  logic               misalign_q, misalign_d;
  logic               misaligned;
`endif

  assign op_in  = ma_rw_e'(rw_e);
  assign len_in = clamp_len(ma_len_e'(rw_len), DATA_L);
  assign off_in = ex_ans[OFF_L-1:0];

  // Offset bits that must be zero for a naturally aligned access of this size.
  always_comb begin
    align_mask = '0;
    case (len_in)
      LEN_B: align_mask = '0;
      LEN_H: align_mask = OFF_L'(1);
      LEN_W: align_mask = OFF_L'(3);
      LEN_D: align_mask = OFF_L'(7);
    endcase
  end

  assign off_fix = off_in & ~align_mask;

`ifdef MA_MISALIGN_EN
  assign misaligned = |(off_in & align_mask);
`endif

  // In IDLE the aligner builds the request from live EX inputs; afterwards it
  // extracts load data using the geometry captured at accept.
  assign la_off = (state_q == IDLE) ? off_fix : off_q;
  assign la_len = (state_q == IDLE) ? len_in  : len_q;

  ma_load_align #(.DATA_L(DATA_L)) u_align (
    .off       (la_off),
    .len       (la_len),
    .is_signed (sign_q),
    .st_data   (ex_din),
    .rd_data   (mem_rdata),
    .be        (la_be),
    .wdata     (la_wdata),
    .ld_data   (la_ld)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_e_d      = wb_e_q;
    wb_idx_d    = wb_idx_q;
    wb_out_d    = wb_out_q;
    off_d       = off_q;
    len_d       = len_q;
    sign_d      = sign_q;
    load_d      = load_q;
    ex_wb_e_d   = ex_wb_e_q;
`ifdef MA_MISALIGN_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (up_valid) begin
          wb_idx_d  = rd;
          ex_wb_e_d = ex_wb_e;
          off_d     = off_fix;
          len_d     = len_in;
          sign_d    = (op_in == MA_LDS);
          load_d    = is_load(op_in);
          if (op_in == MA_NONE) begin
            wb_out_d = DATA_L'(ex_ans);
            wb_e_d   = ex_wb_e;
            state_d  = OUT;
          end
`ifdef MA_MISALIGN_EN
          else if (misaligned) begin
            wb_out_d   = DATA_L'(ex_ans);
            wb_e_d     = 1'b0;
            misalign_d = 1'b1;
            state_d    = OUT;
          end
`endif
          else begin
            mem_we_d    = (op_in == MA_ST);
            mem_addr_d  = {ex_ans[MADDR_L-1:OFF_L], {OFF_L{1'b0}}};
            mem_be_d    = la_be;
            mem_wdata_d = la_wdata;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (!load_q) begin
            wb_e_d  = 1'b0;
            state_d = OUT;
          end else if (mem_rvalid) begin
            // Response can come back in the same cycle as the grant.
            wb_out_d = la_ld;
            wb_e_d   = ex_wb_e_q;
            state_d  = OUT;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          wb_out_d = la_ld;
          wb_e_d   = ex_wb_e_q;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (down_ready) begin
          state_d = IDLE;
`ifdef MA_MISALIGN_EN
          misalign_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_e_q      <= 1'b0;
      wb_idx_q    <= '0;
      wb_out_q    <= '0;
      off_q       <= '0;
      len_q       <= LEN_B;
      sign_q      <= 1'b0;
      load_q      <= 1'b0;
      ex_wb_e_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_e_q      <= wb_e_d;
      wb_idx_q    <= wb_idx_d;
      wb_out_q    <= wb_out_d;
      off_q       <= off_d;
      len_q       <= len_d;
      sign_q      <= sign_d;
      load_q      <= load_d;
      ex_wb_e_q   <= ex_wb_e_d;
    end
  end

`ifdef MA_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign up_ready   = (state_q == IDLE);
  assign mem_req    = (state_q == REQ);
  assign down_valid = (state_q == OUT);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_e       = wb_e_q;
  assign wb_idx     = wb_idx_q;
  assign wb_out     = wb_out_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb_pipe_mem_stage: directed-vector bench for pipe_mem_stage (DATA_L=64).
// Expected WB results are queued when a transaction is issued and checked by
// an independent monitor on each WB handshake; memory-side fields are
// checked directly by the stimulus sequence.
module tb_pipe_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [1:0]  rw_e = 2'b00;
  logic [1:0]  rw_len = 2'b00;
  logic [4:0]  rd = '0;
  logic [31:0] ex_ans = '0;
  logic [63:0] ex_din = '0;
  logic        ex_wb_e = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        down_valid;
  logic        down_ready = 1'b1;
  logic        wb_e;
  logic [4:0]  wb_idx;
  logic [63:0] wb_out;
  logic        misalign;

  typedef struct {
    logic        wbE;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        checkData;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   assertCount = 0;
  int   failCount = 0;

  pipe_mem_stage #(.DATA_L(64), .MADDR_L(32), .RIDX_L(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .rw_e       (rw_e),
    .rw_len     (rw_len),
    .rd         (rd),
    .ex_ans     (ex_ans),
    .ex_din     (ex_din),
    .ex_wb_e    (ex_wb_e),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .wb_e       (wb_e),
    .wb_idx     (wb_idx),
    .wb_out     (wb_out),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] len,
                               input logic [4:0] idx, input logic [31:0] ans,
                               input logic [63:0] din, input logic wbE);
    rw_e     = op;
    rw_len   = len;
    rd       = idx;
    ex_ans   = ans;
    ex_din   = din;
    ex_wb_e  = wbE;
    up_valid = 1'b1;
    checkOutput("up_ready_at_accept", 64'(up_ready), 64'd1);
    step();
    up_valid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_up_ready"},   64'(up_ready),   64'd1);
    checkOutput({tag, "_mem_req"},    64'(mem_req),    64'd0);
    checkOutput({tag, "_mem_we"},     64'(mem_we),     64'd0);
    checkOutput({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
    checkOutput({tag, "_mem_be"},     64'(mem_be),     64'd0);
    checkOutput({tag, "_mem_wdata"},  mem_wdata,       64'd0);
    checkOutput({tag, "_down_valid"}, 64'(down_valid), 64'd0);
    checkOutput({tag, "_wb_e"},       64'(wb_e),       64'd0);
    checkOutput({tag, "_wb_idx"},     64'(wb_idx),     64'd0);
    checkOutput({tag, "_wb_out"},     wb_out,          64'd0);
    checkOutput({tag, "_misalign"},   64'(misalign),   64'd0);
  endtask

  // Monitor: every WB handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && down_valid && down_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wb_handshake", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_wb_e",     64'(wb_e),     64'(e.wbE));
        checkOutput("sb_wb_idx",   64'(wb_idx),   64'(e.idx));
        checkOutput("sb_misalign", 64'(misalign), 64'(e.mis));
        if (e.checkData) checkOutput("sb_wb_out", wb_out, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkResetState("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // Non-memory op: result one cycle after accept, no memory request.
    sb.push_back('{1'b1, 5'd2, 64'h1234, 1'b1, 1'b0});
    applyStimulus(2'b00, 2'b00, 5'd2, 32'h1234, 64'd0, 1'b1);
    checkOutput("none_down_valid", 64'(down_valid), 64'd1);
    checkOutput("none_mem_req",    64'(mem_req),    64'd0);
    step();
    checkOutput("none_done", 64'(down_valid), 64'd0);

    // Store byte at 0x105, grant after three waiting cycles.
    sb.push_back('{1'b0, 5'd3, 64'd0, 1'b0, 1'b0});
    applyStimulus(2'b01, 2'b00, 5'd3, 32'h105, 64'hAB, 1'b1);
    checkOutput("stb_we",    64'(mem_we),   64'd1);
    checkOutput("stb_addr",  64'(mem_addr), 64'h100);
    checkOutput("stb_be",    64'(mem_be),   64'h20);
    checkOutput("stb_wdata", mem_wdata,     64'h0000_AB00_0000_0000);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stb_req_held",  64'(mem_req),  64'd1);
      checkOutput("stb_addr_held", 64'(mem_addr), 64'h100);
      step();
    end
    mem_gnt = 1'b1;
    checkOutput("stb_req_at_gnt", 64'(mem_req), 64'd1);
    step();
    mem_gnt = 1'b0;
    checkOutput("stb_req_dropped", 64'(mem_req),    64'd0);
    checkOutput("stb_down_valid",  64'(down_valid), 64'd1);
    step();

    // Signed half load at 0x206, response two cycles after the grant.
    sb.push_back('{1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0});
    applyStimulus(2'b10, 2'b01, 5'd4, 32'h206, 64'd0, 1'b1);
    checkOutput("lhs_be",   64'(mem_be),   64'hC0);
    checkOutput("lhs_addr", 64'(mem_addr), 64'h200);
    checkOutput("lhs_we",   64'(mem_we),   64'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput("lhs_wait_no_req",   64'(mem_req),    64'd0);
    checkOutput("lhs_wait_no_valid", 64'(down_valid), 64'd0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h8001_0000_0000_0000;
    step();
    mem_rvalid = 1'b0;
    checkOutput("lhs_down_valid", 64'(down_valid), 64'd1);
    step();

    // Unsigned half load, grant and response in the same cycle.
    sb.push_back('{1'b1, 5'd5, 64'h8001, 1'b1, 1'b0});
    applyStimulus(2'b11, 2'b01, 5'd5, 32'h206, 64'd0, 1'b1);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h8001_0000_0000_0000;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput("lhu_down_valid", 64'(down_valid), 64'd1);
    step();

    // Backpressure: WB stalls five cycles while EX keeps offering work.
    down_ready = 1'b0;
    sb.push_back('{1'b0, 5'd6, 64'h55, 1'b1, 1'b0});
    applyStimulus(2'b00, 2'b00, 5'd6, 32'h55, 64'd0, 1'b0);
    rw_e     = 2'b00;
    rd       = 5'd9;
    ex_ans   = 32'h99;
    ex_wb_e  = 1'b1;
    up_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_down_valid", 64'(down_valid), 64'd1);
      checkOutput("bp_up_ready",   64'(up_ready),   64'd0);
      checkOutput("bp_wb_out",     wb_out,          64'h55);
      checkOutput("bp_wb_idx",     64'(wb_idx),     64'd6);
      checkOutput("bp_wb_e",       64'(wb_e),       64'd0);
      step();
    end
    up_valid   = 1'b0;
    down_ready = 1'b1;
    step();
    checkOutput("bp_released", 64'(down_valid), 64'd0);
    step();
    checkOutput("bp_no_extra", 64'(down_valid), 64'd0);

    // Reset while waiting for load data; the late response must be dropped.
    applyStimulus(2'b11, 2'b10, 5'd8, 32'h108, 64'd0, 1'b1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checkResetState("midrst");
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    checkOutput("stale_rvalid_ignored", 64'(down_valid), 64'd0);
    step();
    checkOutput("stale_idle_ready", 64'(up_ready),   64'd1);
    checkOutput("stale_no_valid",   64'(down_valid), 64'd0);

    // Misaligned word load at 0x102.
`ifdef MA_MISALIGN_EN
    sb.push_back('{1'b0, 5'd7, 64'h102, 1'b1, 1'b1});
    applyStimulus(2'b11, 2'b10, 5'd7, 32'h102, 64'd0, 1'b1);
    checkOutput("mis_no_req",      64'(mem_req),    64'd0);
    checkOutput("mis_down_valid",  64'(down_valid), 64'd1);
    checkOutput("mis_flag",        64'(misalign),   64'd1);
    step();
    checkOutput("mis_flag_clears", 64'(misalign),   64'd0);
`else
    sb.push_back('{1'b1, 5'd7, 64'h5566_7788, 1'b1, 1'b0});
    applyStimulus(2'b11, 2'b10, 5'd7, 32'h102, 64'd0, 1'b1);
    checkOutput("mis_be",   64'(mem_be),   64'h0F);
    checkOutput("mis_addr", 64'(mem_addr), 64'h100);
    checkOutput("mis_flag", 64'(misalign), 64'd0);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1122_3344_5566_7788;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    step();
`endif

    // Store double at 0x208: full byte enables, no lane shift.
    sb.push_back('{1'b0, 5'd10, 64'd0, 1'b0, 1'b0});
    applyStimulus(2'b01, 2'b11, 5'd10, 32'h208, 64'h0123_4567_89AB_CDEF, 1'b1);
    checkOutput("std_be",    64'(mem_be),   64'hFF);
    checkOutput("std_addr",  64'(mem_addr), 64'h208);
    checkOutput("std_wdata", mem_wdata,     64'h0123_4567_89AB_CDEF);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();

    // Signed byte load at offset 2 with the top bit set.
    sb.push_back('{1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0});
    applyStimulus(2'b10, 2'b00, 5'd11, 32'h212, 64'd0, 1'b1);
    checkOutput("lbs_be",   64'(mem_be),   64'h04);
    checkOutput("lbs_addr", 64'(mem_addr), 64'h210);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0000_0080_0000;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    step();

    repeat (3) step();
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
